// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the fetch queue stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      HALT_DRAIN = 2'd1,
      HALTED     = 2'd2
   } fetch_state_e;

   localparam int ADDR_W_DEF  = 16;
   localparam int INSTR_W_DEF = 16;
   localparam int PC_STEP_DEF = 2;
   localparam int DEPTH_DEF   = 4;

   // Counters must hold the value DEPTH itself, hence one extra bit.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Instruction-memory, control and decode-side signals of the fetch queue stage.
interface fetch_queue_stage_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
);
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_gnt;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_addr;
   logic               halt;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc;
   logic [ADDR_W-1:0]  out_pc_inc;
   logic               err;

   modport master (
      output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_inc, err,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_addr,
             halt, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_inc, err,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_addr,
             halt, out_ready
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head entry is always visible on rdata.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           wdata,
   input  logic                   pop,
   output logic [W-1:0]           rdata,
   output logic [$clog2(DEPTH):0] count
);
   localparam int CW = cnt_w(DEPTH);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem;
   logic [PW-1:0]           wr_ptr, rd_ptr;
   logic                    do_push, do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && (count != FULL);

   // Storage is cleared on reset so the head reads as zero before any push.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign rdata = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue_stage.sv
// Prefetching fetch stage: pipelined imem requests, in-order PC tags, redirect with stale drop, sticky halt.
// Optional FETCH_ALIGN_CHECK_EN builds the sticky err flag (misaligned redirect / unexpected response).
module fetch_queue_stage
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF,
   parameter int PC_STEP = PC_STEP_DEF,
   parameter int DEPTH   = DEPTH_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 rst,
   fetch_queue_stage_if.master bus
);
   localparam int CW   = cnt_w(DEPTH);
   localparam int PQ_W = INSTR_W + 2 * ADDR_W;
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
   localparam logic [CW:0] CAP = (CW + 1)'(DEPTH);

   fetch_state_e      state, state_nxt;
   logic [ADDR_W-1:0] pc, tag_pc;
   logic [CW-1:0]     occ, outst, drop_cnt;
   logic [PQ_W-1:0]   head;
   logic              redir, resp, drop, issue, pq_push, pq_pop;

   assign redir   = (state == RUN) && bus.redirect_valid && !bus.halt;
   assign resp    = bus.imem_rvalid && (outst != '0);
   assign drop    = resp && (drop_cnt != '0);
   // A response landing in the redirect cycle belongs to the old path.
   assign pq_push = resp && !drop && !redir;

   assign bus.imem_req  = rst && (state == RUN) && !bus.redirect_valid && !bus.halt &&
                          (({1'b0, occ} + {1'b0, outst}) < CAP);
   assign bus.imem_addr = pc;
   assign issue         = bus.imem_req && bus.imem_gnt;

   assign bus.out_valid = (state != HALTED) && (occ != '0);
   assign pq_pop        = bus.out_valid && bus.out_ready;
   assign {bus.out_instr, bus.out_pc, bus.out_pc_inc} = head;

   always_ff @(posedge clk) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         RUN:        if (bus.halt) state_nxt = HALT_DRAIN;
         HALT_DRAIN: if (outst == '0) state_nxt = HALTED;
         HALTED:     state_nxt = HALTED;
         default:    state_nxt = RUN;
      endcase
   end

   // outstanding stays intact across a redirect; drop_cnt marks how many of them are stale.
   always_ff @(posedge clk) begin
      if (!rst) begin
         pc       <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         if (redir)      pc <= bus.redirect_addr;
         else if (issue) pc <= pc + STEP;
         if (redir)      drop_cnt <= outst - CW'(resp);
         else if (drop)  drop_cnt <= drop_cnt - 1'b1;
      end
   end

   fetch_fifo #(.W(ADDR_W), .DEPTH(DEPTH)) u_tag_q (
      .clk   (clk),
      .rst   (rst),
      .flush (1'b0),
      .push  (issue),
      .wdata (pc),
      .pop   (resp),
      .rdata (tag_pc),
      .count (outst)
   );

   // pc_inc is stored per entry so a reset/empty head reads as all zero.
   fetch_fifo #(.W(PQ_W), .DEPTH(DEPTH)) u_prefetch_q (
      .clk   (clk),
      .rst   (rst),
      .flush (redir),
      .push  (pq_push),
      .wdata ({bus.imem_rdata, tag_pc, tag_pc + STEP}),
      .pop   (pq_pop),
      .rdata (head),
      .count (occ)
   );

`ifdef FETCH_ALIGN_CHECK_EN
   logic err_q;
   always_ff @(posedge clk) begin
      if (!rst) err_q <= 1'b0;
      else if ((redir && ((bus.redirect_addr & (STEP - 1'b1)) != '0)) ||
               (bus.imem_rvalid && (outst == '0)))
         err_q <= 1'b1;
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Randomized scoreboard bench: memory model with variable latency, expected PC stream from redirect targets.
module tb_fetch_queue_stage;
   import fetch_pkg::*;

   localparam int AW = 16, IW = 16, DEPTH = 4;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct { logic [15:0] pc, instr, inc; } exp_t;
   typedef struct { int due; logic [15:0] addr; } mreq_t;

   logic clk = 1'b0, rst = 1'b0;
   always #5 clk = ~clk;

   fetch_queue_stage_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();
   fetch_queue_stage #(.ADDR_W(AW), .INSTR_W(IW), .PC_STEP(2), .DEPTH(DEPTH),
                       .RESET_PC(16'h0000)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t        exp_q[$];
   mreq_t       mq[$];
   logic [15:0] exp_tail;
   int checks = 0, errors = 0, cyc = 0, last_due = 0;
   int lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100;
   int grants = 0, deliveries = 0;
   bit halt_sticky = 1'b0, spurious = 1'b0;

   function automatic logic [15:0] instr_of(input logic [15:0] a);
      return (a * 16'h9E37) ^ 16'h5A5A;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 16) begin
         exp_q.push_back('{pc: exp_tail, instr: instr_of(exp_tail), inc: exp_tail + 16'd2});
         exp_tail = exp_tail + 16'd2;
      end
   endtask

   task automatic sb_reset(input logic [15:0] base);
      exp_q.delete();
      exp_tail = base;
      refill();
   endtask

   // Inputs change 1 time unit after each rising edge; the memory presents due responses in order.
   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      bus.imem_gnt       = ($urandom_range(99) < gnt_pct);
      bus.out_ready      = ($urandom_range(99) < rdy_pct);
      bus.redirect_valid = 1'b0;
      bus.halt           = 1'b0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = instr_of(mq[0].addr);
         void'(mq.pop_front());
      end else if (spurious) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = 16'hDEAD;
         spurious        = 1'b0;
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = 16'($urandom);
      end
   endtask

   task automatic do_redirect(input logic [15:0] a, input bit with_halt);
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_addr  = a;
      if (with_halt) begin
         bus.halt    = 1'b1;
         halt_sticky = 1'b1;
      end else if (!halt_sticky) begin
         sb_reset(a);
      end
   endtask

   task automatic redirect_and_check(input logic [15:0] a);
      do_redirect(a, 1'b0);
      step();
      chk("redir_next_addr", bus.imem_addr, a);
   endtask

   task automatic do_reset();
      step();
      rst = 1'b0;
      mq.delete();
      last_due    = 0;
      halt_sticky = 1'b0;
      spurious    = 1'b0;
      step();
      step();
      chk("rst_imem_req",   bus.imem_req,   0);
      chk("rst_out_valid",  bus.out_valid,  0);
      chk("rst_out_instr",  bus.out_instr,  0);
      chk("rst_out_pc",     bus.out_pc,     0);
      chk("rst_out_pc_inc", bus.out_pc_inc, 0);
      chk("rst_err",        bus.err,        0);
      step();
      rst = 1'b1;
      sb_reset(16'h0000);
   endtask

   task automatic run_random(input int n, input bit redirects);
      for (int i = 0; i < n; i++) begin
         if (redirects && $urandom_range(19) == 0)
            do_redirect(16'($urandom) & 16'hFFFE, 1'b0);
         else
            step();
      end
   endtask

   // Monitor: records granted requests for the memory model and scores every delivered instruction.
   always @(negedge clk) begin : mon
      exp_t e;
      int   due;
      if (rst) begin
         if (bus.imem_req && bus.imem_gnt) begin
            grants++;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq.push_back('{due: due, addr: bus.imem_addr});
         end
         if (halt_sticky) chk("no_req_after_halt", bus.imem_req, 0);
         if (bus.out_valid && bus.out_ready && !(bus.redirect_valid && !halt_sticky)) begin
            deliveries++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty actual=pc %h required=no delivery", bus.out_pc);
            end else begin
               e = exp_q.pop_front();
               chk("out_pc",     bus.out_pc,     e.pc);
               chk("out_instr",  bus.out_instr,  e.instr);
               chk("out_pc_inc", bus.out_pc_inc, e.inc);
               refill();
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int d0;
      bit hit;
      bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      bus.redirect_valid = 1'b0; bus.redirect_addr = '0; bus.halt = 1'b0; bus.out_ready = 1'b0;

      // Reset, first-request and first-valid latency with a 1-cycle memory.
      do_reset();
      #1;
      chk("req_in_release_cycle", bus.imem_req, 1);
      step();
      chk("no_valid_cycle1", bus.out_valid, 0);
      step();
      chk("valid_cycle2", bus.out_valid, 1);

      // Sustained throughput.
      repeat (10) step();
      d0 = deliveries;
      repeat (20) step();
      chk("throughput", deliveries - d0, 20);

      // Decode stalled: exactly DEPTH grants, then requests stop.
      rdy_pct = 0;
      repeat (20) step();
      do_redirect(16'h0040, 1'b0);
      grants = 0;
      repeat (20) step();
      chk("stall_grants", grants, DEPTH);
      chk("stall_req_low", bus.imem_req, 0);
      rdy_pct = 100;
      repeat (30) step();

      // 3-cycle memory, redirect with two responses in flight.
      lat_min = 3; lat_max = 3;
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         step();
         hit = (mq.size() == 2);
      end
      chk("two_outstanding_reached", hit, 1);
      redirect_and_check(16'h0100);
      repeat (30) step();

      // Randomized traffic with random redirects.
      lat_min = 1; lat_max = 3; gnt_pct = 70; rdy_pct = 70;
      run_random(300, 1'b1);

      // Address wrap.
      lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
      redirect_and_check(16'hFFFC);
      repeat (20) step();

      // Misaligned redirect.
      redirect_and_check(16'h0101);
      chk("err_misalign", bus.err, ERR_EN);
      repeat (10) step();
      chk("err_sticky", bus.err, ERR_EN);

      // Halt together with redirect: halt wins, drain, then terminal.
      lat_min = 2; lat_max = 2;
      do_redirect(16'h0200, 1'b1);
      step();
      chk("halt_ignores_redirect", bus.imem_addr != 16'h0200, 1);
      hit = 1'b0;
      for (int i = 0; i < 50 && !hit; i++) begin
         step();
         hit = (mq.size() == 0) && !bus.imem_rvalid;
      end
      chk("halt_drained", hit, 1);
      repeat (3) step();
      for (int i = 0; i < 4; i++) begin
         chk("halted_out_valid", bus.out_valid, 0);
         chk("halted_imem_req",  bus.imem_req,  0);
         step();
      end
      spurious = 1'b1;
      step();
      step();
      chk("err_spurious", bus.err, ERR_EN);
      chk("halted_after_spurious", bus.out_valid, 0);

      // Reset out of HALTED, traffic, then reset mid-operation.
      do_reset();
      lat_min = 1; lat_max = 3; gnt_pct = 80; rdy_pct = 80;
      run_random(60, 1'b0);
      do_reset();
      run_random(40, 1'b1);
      chk("final_err", bus.err, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
